shiftreg_out: RTL

//   Serialises the parallel LED word from the encoder/counter stage into an

---
 rtl/shiftreg_out_pkg.sv | 16 +
 rtl/shiftreg_out_timer.sv | 37 +++
 rtl/shiftreg_out.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/shiftreg_out_pkg.sv
// Shared FSM encoding and width helper for the shiftreg_out serialiser.
package shiftreg_out_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SHIFT_LO = 2'd1,
    SHIFT_HI = 2'd2,
    LATCH    = 2'd3
  } state_e;

  // Bits needed to hold 0..n-1, never less than one.
  function automatic int unsigned width_of(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/shiftreg_out_timer.sv
// Phase down-counter: reloads to CLK_DIV-1 on load, tick on terminal count (last cycle of a phase).
module phase_timer
  import shiftreg_out_pkg::*;
#(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  output logic tick
);

  localparam int unsigned          CNT_W  = width_of(CLK_DIV + 1);
  localparam logic [CNT_W-1:0]     RELOAD = CNT_W'(CLK_DIV - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = RELOAD;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= RELOAD;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick = (cnt_q == '0);

endmodule

// File: rtl/shiftreg_out.sv
// Serialises the LED word into a 74HC595-style register: MSB first on ser/sck, then an rck latch pulse.
//
//   state    | meaning
//   ---------+---------------------------------------------------
//   IDLE     | waiting for data to differ from the word last sent
//   SHIFT_LO | sck low, ser settling for the current bit
//   SHIFT_HI | sck high, external register samples ser
//   LATCH    | rck high, word copied to the chip outputs
module shiftreg_out
  import shiftreg_out_pkg::*;
#(
  parameter int unsigned DATA_N  = 8,
  parameter int unsigned CLK_DIV = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_N-1:0] data,
  output logic              ser,
  output logic              sck,
  output logic              rck,
  output logic              busy,
  output logic              done
);

  localparam int unsigned      IDX_W   = width_of(DATA_N);
  localparam logic [IDX_W-1:0] IDX_TOP = IDX_W'(DATA_N - 1);

  state_e              state_q, state_d;
  logic [DATA_N-1:0]   shadow_q, shadow_d;
  logic [DATA_N-1:0]   sent_q, sent_d;
  logic                init_q, init_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [IDX_W-1:0]    idx_dec;
  logic                ser_q, ser_d;
  logic                sck_q, sck_d;
  logic                rck_q, rck_d;
  logic                busy_q, busy_d;
  logic                done_c;
  logic                timer_load;
  logic                phase_tick;

  phase_timer #(
    .CLK_DIV(CLK_DIV)
  ) u_timer (
    .clk  (clk),
    .rst  (rst),
    .load (timer_load),
    .tick (phase_tick)
  );

  assign idx_dec = idx_q - 1'b1;

  always_comb begin
    state_d  = state_q;
    shadow_d = shadow_q;
    sent_d   = sent_q;
    init_d   = init_q;
    idx_d    = idx_q;
    ser_d    = ser_q;
    sck_d    = sck_q;
    rck_d    = rck_q;
    busy_d   = busy_q;
    done_c   = 1'b0;
    unique case (state_q)
      IDLE: begin
        // init_q forces one transfer after reset so the chip is cleared.
        if (init_q || (data != sent_q)) begin
          state_d  = SHIFT_LO;
          shadow_d = data;
          sent_d   = data;
          init_d   = 1'b0;
          idx_d    = IDX_TOP;
          busy_d   = 1'b1;
          ser_d    = data[DATA_N-1];
        end
      end
      SHIFT_LO: begin
        if (phase_tick) begin
          state_d = SHIFT_HI;
          sck_d   = 1'b1;
        end
      end
      SHIFT_HI: begin
        if (phase_tick) begin
          sck_d = 1'b0;
          if (idx_q != '0) begin
            idx_d   = idx_dec;
            ser_d   = shadow_q[idx_dec];
            state_d = SHIFT_LO;
          end else begin
            ser_d   = 1'b0;
            rck_d   = 1'b1;
            state_d = LATCH;
          end
        end
      end
      LATCH: begin
        if (phase_tick) begin
          done_c  = 1'b1;
          rck_d   = 1'b0;
          busy_d  = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Every phase starts with a full CLK_DIV count.
  assign timer_load = (state_d != state_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      shadow_q <= '0;
      sent_q   <= '0;
      init_q   <= 1'b1;
      idx_q    <= '0;
      ser_q    <= 1'b0;
      sck_q    <= 1'b0;
      rck_q    <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      shadow_q <= shadow_d;
      sent_q   <= sent_d;
      init_q   <= init_d;
      idx_q    <= idx_d;
      ser_q    <= ser_d;
      sck_q    <= sck_d;
      rck_q    <= rck_d;
      busy_q   <= busy_d;
    end
  end

  assign ser  = ser_q;
  assign sck  = sck_q;
  assign rck  = rck_q;
  assign busy = busy_q;
  assign done = done_c;

endmodule
